// File: rtl/key_debounce_pulse.sv
// Key conditioner: 2-flop sync, per-key debounce counter, registered press pulse (optional auto-repeat via KEY_REPEAT_EN).
// Latency: raw change before edge k -> key_level/key_pulse/key_any update at edge k+1+CNT_MAX.
// Backpressure: none; pulses are single-cycle strobes and the consumer must sample every cycle.
module key_debounce_pulse #(
    parameter int                N_KEYS        = 9,
    parameter int                CNT_MAX       = 1000000,
    parameter int                REPEAT_DELAY  = 50000000,
    parameter int                REPEAT_PERIOD = 20000000,
    parameter logic [N_KEYS-1:0] REPEAT_MASK   = 9'b1_1111_0000
) (
    input  logic              sys_clk,
    input  logic              sys_rst_n,
    input  logic [N_KEYS-1:0] key_raw,
    output logic [N_KEYS-1:0] key_level,
    output logic [N_KEYS-1:0] key_pulse,
    output logic              key_any
);

    localparam int            CW       = $clog2(CNT_MAX + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(CNT_MAX - 1);

    logic [N_KEYS-1:0] sync1;
    logic [N_KEYS-1:0] sync2;
    logic [CW-1:0]     cnt     [N_KEYS];
    logic [CW-1:0]     cnt_nxt [N_KEYS];
    logic [N_KEYS-1:0] level_nxt;
    logic [N_KEYS-1:0] press;
    logic [N_KEYS-1:0] rep_fire;

    // Two-flop synchroniser; only sync2 is seen by the debounce logic
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= key_raw;
            sync2 <= sync1;
        end
    end

    // Debounce next state: count consecutive disagreeing cycles, accept on the last one
    always_comb begin
        level_nxt = key_level;
        for (int i = 0; i < N_KEYS; i++) begin
            cnt_nxt[i] = '0;
            if (sync2[i] != key_level[i]) begin
                if (cnt[i] == CNT_LAST) begin
                    level_nxt[i] = sync2[i];
                end else begin
                    cnt_nxt[i] = cnt[i] + 1'b1;
                end
            end
        end
    end

    // A press is the accepted 0->1 transition of the debounced level
    assign press = level_nxt & ~key_level;

    // Debounce state and registered outputs; key_any tracks the level it summarises
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            for (int i = 0; i < N_KEYS; i++) begin
                cnt[i] <= '0;
            end
            key_level <= '0;
            key_pulse <= '0;
            key_any   <= 1'b0;
        end else begin
            for (int i = 0; i < N_KEYS; i++) begin
                cnt[i] <= cnt_nxt[i];
            end
            key_level <= level_nxt;
            key_pulse <= press | rep_fire;
            key_any   <= |level_nxt;
        end
    end

`ifdef KEY_REPEAT_EN
    localparam int REP_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = $clog2(REP_MAX + 1);

    for (genvar i = 0; i < N_KEYS; i++) begin : g_rep
        if (REPEAT_MASK[i]) begin : g_on
            logic [RW-1:0] rep_cnt;
            logic          rep_phase;
            logic          held;

            // Held means the level was 1 and stays 1 this cycle; the press and release cycles are excluded
            assign held        = key_level[i] & level_nxt[i];
            assign rep_fire[i] = held & (rep_cnt == (rep_phase ? RW'(REPEAT_PERIOD - 1)
                                                               : RW'(REPEAT_DELAY - 1)));

            // Repeat timer: first interval is the delay, later ones the period; cleared when not held
            always_ff @(posedge sys_clk or negedge sys_rst_n) begin
                if (!sys_rst_n) begin
                    rep_cnt   <= '0;
                    rep_phase <= 1'b0;
                end else if (!held) begin
                    rep_cnt   <= '0;
                    rep_phase <= 1'b0;
                end else if (rep_fire[i]) begin
                    rep_cnt   <= '0;
                    rep_phase <= 1'b1;
                end else begin
                    rep_cnt   <= rep_cnt + 1'b1;
                end
            end
        end else begin : g_off
            assign rep_fire[i] = 1'b0;
        end
    end
`else
    assign rep_fire = '0;

    // Repeat parameters are accepted but have no effect in this build
    if (REPEAT_DELAY < 1 || REPEAT_PERIOD < 1 || REPEAT_MASK == '0) begin : g_repeat_ignored
    end
`endif

endmodule
